hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard unit for the five-stage MIPS core (addu, subu, xor, nor, lw, sw, lui, ori, beq, j, jr, jal, jalr, clo, clz). It sits directly downstream of the decode-stage control decoder and consumes its one-hot instruction class, write-enable and resolved destination register each cycle. It keeps its own E/M/W shadow pipeline of those fields, and from them produces the stall request and all forwarding-mux selects. A saturating stall counter is kept for performance debug.

## Interface
- CNT_W, 32, width of stall counter
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- d_type  in  7  one-hot class of D instruction: bit0 R, bit1 I, bit2 B, bit3 Store, bit4 Load, bit5 Jl, bit6 Jr; 0 = nop/j
- d_rs, d_rt  in  5 each  D source register fields
- d_we  in  1  D instruction writes GPR
- d_wreg  in  5  D destination (rd, rt or 31, already selected)
- stall  out  1  freeze PC and IF/ID, inject bubble into ID/EX
- fwd_d_rs, fwd_d_rt  out  2 each  D compare/jump operand select: 00 RF, 01 E link value, 10 M result, 11 W result
- fwd_e_rs, fwd_e_rt  out  2 each  E ALU operand select: 00 pipeline reg, 10 M result, 11 W result; 01 never driven
- fwd_m_rt  out  1  sw store data: 0 pipeline reg, 1 W result
- stall_cnt  out  CNT_W  number of stall cycles since reset, saturating

## Operation
- Shadow regs per stage X∈{E,M,W}: x_type, x_rs, x_rt, x_we, x_wreg. A stage "writes r" iff x_we & x_wreg==r & r!=0.
- Tuse (D): B: rs,rt=0; Jr: rs=0; R: rs,rt=1; I: rs=1; Load: rs=1; Store: rs=1, rt=2. Unused operands never stall/forward.
- Tnew at E: Jl=0, R/I=1, Load=2. At M: Load=1, else 0. At W: 0.
- stall=1 iff some used D operand r, Tuse(r) < Tnew of E writing r, or Tuse(r) < Tnew of M writing r. Combinational.
- fwd_d_*: nearest writer wins, E>M>W; E selected only when E class is Jl (Tnew 0); E writer with Tnew>0 shadows older stages (stall is asserted, select = 00).
- fwd_e_*: M writer (non-Load) > W writer > 00. Load in M writing the operand cannot occur (stalled earlier).
- fwd_m_rt: 1 iff M class Store and W writes m_rt.
- Stall counter increments once per cycle with stall=1; holds at all-ones.

## Timing
- Reset (async assert, sync-to-clk release): all shadow regs 0, stall_cnt 0; hence stall=0 and all selects 0 during and after reset.
- Every edge: W←M, M←E. E←D fields if stall=0, else E←bubble (all fields 0).
- Outputs combinational from D inputs and shadow regs, zero latency; stall valid same cycle the consumer arrives in D.
- Load-use on R: one stall cycle. Load then beq/jr on same reg: two stall cycles. R/I then beq: one stall. jal then jr $31: no stall, fwd_d_rs=01.
- Simultaneous E and M writers of same reg: E wins (youngest). Register 0 never matches.
- Reset mid-stall: stall drops immediately with reset; bubble state lost, pipeline restarts empty.

## Structure
- Shared package core_pkg: one-hot class constants (R/I/B/Store/Load/Jl/Jr), forwarding select encodings, Tuse/Tnew constants; the control decoder uses the same class constants.
- One sub-module: hazard_stage_reg (one shadow stage, load/bubble input), instantiated for E, M, W. Tnew/Tuse logic and counter stay in top.

## Test plan
- lw $1 then addu $2,$1,$3 -> stall=1 for one cycle, stall_cnt 1; next cycle fwd_e_rs=11 (W) for addu in E.
- ori $4,$0,5 then beq $4,$0 -> one stall; beq re-evaluated with fwd_d_rs=10.
- lw $5 then jr $5 -> stall two cycles, then fwd_d_rs=11; stall_cnt 2.
- jal then jr $31 in slot -> stall=0, fwd_d_rs=01.
- addu $6 then sw $6,0($7) -> no stall; sw in E fwd_e_rt=10; addu $0 writer -> all selects 00.
- Assert rst_n low during load-use stall -> stall=0, stall_cnt=0, selects 00 immediately; force 2^CNT_W stalls (CNT_W=4) -> counter holds 15.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions for the decode-side control path.
// Holds the one-hot instruction class encoding (also used by the control
// decoder), the forwarding-select encodings, the per-class Tuse/Tnew timing
// constants and small helpers that map an instruction class onto them.
package core_pkg;

  localparam int CLS_W = 7;
  localparam int REG_W = 5;

  // One-hot instruction classes; all-zero is a nop or a plain j.
  localparam logic [CLS_W-1:0] CLS_NONE  = 7'b000_0000;
  localparam logic [CLS_W-1:0] CLS_R     = 7'b000_0001;
  localparam logic [CLS_W-1:0] CLS_I     = 7'b000_0010;
  localparam logic [CLS_W-1:0] CLS_B     = 7'b000_0100;
  localparam logic [CLS_W-1:0] CLS_STORE = 7'b000_1000;
  localparam logic [CLS_W-1:0] CLS_LOAD  = 7'b001_0000;
  localparam logic [CLS_W-1:0] CLS_JL    = 7'b010_0000;
  localparam logic [CLS_W-1:0] CLS_JR    = 7'b100_0000;

  // Forwarding-mux select encodings.
  localparam logic [1:0] FWD_RF = 2'b00;  // register file / pipeline register
  localparam logic [1:0] FWD_E  = 2'b01;  // link value produced in E
  localparam logic [1:0] FWD_M  = 2'b10;  // M-stage result
  localparam logic [1:0] FWD_W  = 2'b11;  // W-stage result

  // Cycles until an operand is consumed, counted from D.
  localparam logic [1:0] TUSE_BRANCH   = 2'd0;
  localparam logic [1:0] TUSE_ALU      = 2'd1;
  localparam logic [1:0] TUSE_STORE_RT = 2'd2;

  // Cycles until a result exists, counted from the stage it sits in.
  localparam logic [1:0] TNEW_E_LINK = 2'd0;
  localparam logic [1:0] TNEW_E_ALU  = 2'd1;
  localparam logic [1:0] TNEW_E_LOAD = 2'd2;
  localparam logic [1:0] TNEW_M_LOAD = 2'd1;
  localparam logic [1:0] TNEW_NONE   = 2'd0;

  typedef struct packed {
    logic       used;
    logic [1:0] t;
  } tuse_t;

  localparam tuse_t TUSE_UNUSED = '{used: 1'b0, t: 2'd0};

  function automatic tuse_t tuse_rs(input logic [CLS_W-1:0] cls);
    tuse_t u;
    case (cls)
      CLS_B, CLS_JR:                     u = '{used: 1'b1, t: TUSE_BRANCH};
      CLS_R, CLS_I, CLS_LOAD, CLS_STORE: u = '{used: 1'b1, t: TUSE_ALU};
      default:                           u = TUSE_UNUSED;
    endcase
    return u;
  endfunction

  function automatic tuse_t tuse_rt(input logic [CLS_W-1:0] cls);
    tuse_t u;
    case (cls)
      CLS_B:     u = '{used: 1'b1, t: TUSE_BRANCH};
      CLS_R:     u = '{used: 1'b1, t: TUSE_ALU};
      CLS_STORE: u = '{used: 1'b1, t: TUSE_STORE_RT};
      default:   u = TUSE_UNUSED;
    endcase
    return u;
  endfunction

  function automatic logic [1:0] tnew_e(input logic [CLS_W-1:0] cls);
    logic [1:0] t;
    case (cls)
      CLS_R, CLS_I: t = TNEW_E_ALU;
      CLS_LOAD:     t = TNEW_E_LOAD;
      // Link writers (jal, jalr) have their value ready in E.
      default:      t = TNEW_E_LINK;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] tnew_m(input logic [CLS_W-1:0] cls);
    return (cls == CLS_LOAD) ? TNEW_M_LOAD : TNEW_NONE;
  endfunction

  // A stage writes r only when enabled, targeting r, and r is not $0.
  function automatic logic writes(input logic we, input logic [REG_W-1:0] wreg,
                                  input logic [REG_W-1:0] r);
    return we && (wreg == r) && (r != '0);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage of the hazard unit.
// Ports: clk, rst_n (async active-low clear); bubble (load zeros instead of d);
// d (packed fields from the previous stage); q (registered fields).
module hazard_stage_reg #(
  parameter int W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so each stage
  // captures the previous stage's pre-edge value, not one updated this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit for the five-stage MIPS core.
// Shadows the decoder's class/write fields through E, M and W and derives the
// stall request and all forwarding selects from Tuse/Tnew timing.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   d_type, d_rs, d_rt, d_we, d_wreg decoded fields of the instruction in D
//   stall                           freeze PC/IF-ID, bubble into ID/EX
//   fwd_d_rs, fwd_d_rt              D compare/jump operand selects
//   fwd_e_rs, fwd_e_rt              E ALU operand selects
//   fwd_m_rt                        store-data select in M
//   stall_cnt                       saturating count of stall cycles
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       d_type,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic             d_we,
  input  logic [4:0]       d_wreg,
  output logic             stall,
  output logic [1:0]       fwd_d_rs,
  output logic [1:0]       fwd_d_rt,
  output logic [1:0]       fwd_e_rs,
  output logic [1:0]       fwd_e_rt,
  output logic             fwd_m_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  // E carries every field; M no longer needs rs, and W is only ever
  // consulted as a writer, so it keeps just the write port.
  localparam int E_W = CLS_W + 3 * REG_W + 1;
  localparam int M_W = CLS_W + 2 * REG_W + 1;
  localparam int W_W = REG_W + 1;

  logic [E_W-1:0]   e_q;
  logic [M_W-1:0]   m_q;
  logic [W_W-1:0]   w_q;
  logic [CLS_W-1:0] e_type, m_type;
  logic [REG_W-1:0] e_rs, e_rt, e_wreg, m_rt, m_wreg, w_wreg;
  logic             e_we, m_we, w_we;

  hazard_stage_reg #(.W(E_W)) u_stage_e (
    .clk(clk), .rst_n(rst_n), .bubble(stall),
    .d({d_type, d_rs, d_rt, d_we, d_wreg}), .q(e_q)
  );
  hazard_stage_reg #(.W(M_W)) u_stage_m (
    .clk(clk), .rst_n(rst_n), .bubble(1'b0),
    .d({e_type, e_rt, e_we, e_wreg}), .q(m_q)
  );
  hazard_stage_reg #(.W(W_W)) u_stage_w (
    .clk(clk), .rst_n(rst_n), .bubble(1'b0),
    .d({m_we, m_wreg}), .q(w_q)
  );

  assign {e_type, e_rs, e_rt, e_we, e_wreg} = e_q;
  assign {m_type, m_rt, m_we, m_wreg}       = m_q;
  assign {w_we, w_wreg}                     = w_q;

  // Operand is consumed before the producer in that stage has its result.
  function automatic logic late(input tuse_t u, input logic e_hit, input logic [1:0] e_t,
                                input logic m_hit, input logic [1:0] m_t);
    return u.used && ((e_hit && (u.t < e_t)) || (m_hit && (u.t < m_t)));
  endfunction

  // Youngest writer wins; a not-yet-ready E writer masks older stages and
  // leaves the select at RF while the stall holds the consumer.
  function automatic logic [1:0] sel_d(input tuse_t u, input logic e_hit, input logic [1:0] e_t,
                                       input logic m_hit, input logic w_hit);
    logic [1:0] s;
    s = FWD_RF;
    if (u.used) begin
      if (e_hit)      s = (e_t == TNEW_E_LINK) ? FWD_E : FWD_RF;
      else if (m_hit) s = FWD_M;
      else if (w_hit) s = FWD_W;
    end
    return s;
  endfunction

  function automatic logic [1:0] sel_e(input tuse_t u, input logic m_hit, input logic w_hit);
    logic [1:0] s;
    s = FWD_RF;
    if (u.used) begin
      if (m_hit)      s = FWD_M;
      else if (w_hit) s = FWD_W;
    end
    return s;
  endfunction

  tuse_t      d_use_rs, d_use_rt, e_use_rs, e_use_rt;
  logic [1:0] e_tnew, m_tnew;
  logic       e_hit_rs, m_hit_rs, w_hit_rs, e_hit_rt, m_hit_rt, w_hit_rt;
  logic       m_alu;

  assign d_use_rs = tuse_rs(d_type);
  assign d_use_rt = tuse_rt(d_type);
  assign e_use_rs = tuse_rs(e_type);
  assign e_use_rt = tuse_rt(e_type);
  assign e_tnew   = tnew_e(e_type);
  assign m_tnew   = tnew_m(m_type);

  assign e_hit_rs = writes(e_we, e_wreg, d_rs);
  assign m_hit_rs = writes(m_we, m_wreg, d_rs);
  assign w_hit_rs = writes(w_we, w_wreg, d_rs);
  assign e_hit_rt = writes(e_we, e_wreg, d_rt);
  assign m_hit_rt = writes(m_we, m_wreg, d_rt);
  assign w_hit_rt = writes(w_we, w_wreg, d_rt);

  assign stall = late(d_use_rs, e_hit_rs, e_tnew, m_hit_rs, m_tnew)
               | late(d_use_rt, e_hit_rt, e_tnew, m_hit_rt, m_tnew);

  assign fwd_d_rs = sel_d(d_use_rs, e_hit_rs, e_tnew, m_hit_rs, w_hit_rs);
  assign fwd_d_rt = sel_d(d_use_rt, e_hit_rt, e_tnew, m_hit_rt, w_hit_rt);

  // A load in M has no result on the M bus yet; fall through to W.
  assign m_alu    = (m_type != CLS_LOAD);
  assign fwd_e_rs = sel_e(e_use_rs, m_alu && writes(m_we, m_wreg, e_rs), writes(w_we, w_wreg, e_rs));
  assign fwd_e_rt = sel_e(e_use_rt, m_alu && writes(m_we, m_wreg, e_rt), writes(w_we, w_wreg, e_rt));

  assign fwd_m_rt = (m_type == CLS_STORE) && writes(w_we, w_wreg, m_rt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios followed by
// random instruction streams, all compared against a table-driven model.
module tb_hazard_ctrl;

  localparam int CNT_W  = 4;
  localparam int MAXCNT = (1 << CNT_W) - 1;

  // Class indices (bit position in d_type); -1 is nop/j.
  localparam int R = 0, I = 1, B = 2, ST = 3, LD = 4, JL = 5, JR = 6;

  logic             clk;
  logic             rst_n;
  logic [6:0]       d_type;
  logic [4:0]       d_rs, d_rt, d_wreg;
  logic             d_we;
  logic             stall;
  logic [1:0]       fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic             fwd_m_rt;
  logic [CNT_W-1:0] stall_cnt;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_type(d_type), .d_rs(d_rs), .d_rt(d_rt), .d_we(d_we), .d_wreg(d_wreg),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cls;
    int rs;
    int rt;
    bit we;
    int wreg;
  } ins_t;

  // Timing tables indexed by class: -1 marks an operand the class never reads.
  int tuse_rs_tab [7] = '{1, 1, 0, 1, 1, -1, 0};
  int tuse_rt_tab [7] = '{1, -1, 0, 2, -1, -1, -1};
  int tnew_e_tab  [7] = '{1, 1, 0, 0, 2, 0, 0};

  ins_t cur, pipe_e, pipe_m, pipe_w;
  int   model_cnt;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic       obs_stall, obs_fm;
  logic [1:0] obs_fd_rs, obs_fd_rt, obs_fe_rs, obs_fe_rt;
  logic [CNT_W-1:0] obs_cnt;

  function automatic ins_t mk(input int cls, input int rs, input int rt, input bit we, input int wreg);
    ins_t s;
    s.cls = cls; s.rs = rs; s.rt = rt; s.we = we; s.wreg = wreg;
    return s;
  endfunction

  function automatic ins_t nop();                   return mk(-1, 0, 0, 1'b0, 0);    endfunction
  function automatic ins_t lw(input int t, input int b);  return mk(LD, b, t, 1'b1, t); endfunction
  function automatic ins_t addu(input int d, input int s, input int t); return mk(R, s, t, 1'b1, d); endfunction
  function automatic ins_t ori(input int t, input int s); return mk(I, s, t, 1'b1, t); endfunction
  function automatic ins_t beq(input int s, input int t); return mk(B, s, t, 1'b0, 0); endfunction
  function automatic ins_t jr(input int s);         return mk(JR, s, 0, 1'b0, 0);    endfunction
  function automatic ins_t jal();                   return mk(JL, 0, 0, 1'b1, 31);   endfunction
  function automatic ins_t sw(input int t, input int b);  return mk(ST, b, t, 1'b0, 0); endfunction

  // ---------------- reference model ----------------
  function automatic int use_of(input ins_t s, input bit rt_op);
    if (s.cls < 0) return -1;
    return rt_op ? tuse_rt_tab[s.cls] : tuse_rs_tab[s.cls];
  endfunction

  function automatic bit wr(input ins_t s, input int r);
    return s.we && (s.wreg == r) && (r != 0);
  endfunction

  function automatic int tnew_in_e(input ins_t s);
    return (s.cls < 0) ? 0 : tnew_e_tab[s.cls];
  endfunction

  function automatic int tnew_in_m(input ins_t s);
    return (s.cls == LD) ? 1 : 0;
  endfunction

  function automatic bit exp_stall();
    bit s = 1'b0;
    for (int op = 0; op < 2; op++) begin
      int u = use_of(cur, op[0]);
      int r = (op == 1) ? cur.rt : cur.rs;
      if (u >= 0 && ((wr(pipe_e, r) && u < tnew_in_e(pipe_e)) ||
                     (wr(pipe_m, r) && u < tnew_in_m(pipe_m))))
        s = 1'b1;
    end
    return s;
  endfunction

  function automatic int exp_fd(input bit rt_op);
    int r = rt_op ? cur.rt : cur.rs;
    if (use_of(cur, rt_op) < 0) return 0;
    if (wr(pipe_e, r))          return (tnew_in_e(pipe_e) == 0) ? 1 : 0;
    if (wr(pipe_m, r))          return 2;
    if (wr(pipe_w, r))          return 3;
    return 0;
  endfunction

  function automatic int exp_fe(input bit rt_op);
    int r = rt_op ? pipe_e.rt : pipe_e.rs;
    if (use_of(pipe_e, rt_op) < 0)         return 0;
    if (wr(pipe_m, r) && pipe_m.cls != LD) return 2;
    if (wr(pipe_w, r))                     return 3;
    return 0;
  endfunction

  function automatic int exp_fm();
    return (pipe_m.cls == ST && wr(pipe_w, pipe_m.rt)) ? 1 : 0;
  endfunction

  function automatic int pick_reg();
    int r = $urandom_range(0, 4);
    return (r == 4) ? 31 : r;
  endfunction

  function automatic ins_t rnd_ins();
    int k = $urandom_range(0, 7);
    int a = pick_reg();
    int b = pick_reg();
    int c = pick_reg();
    case (k)
      0: return addu(a, b, c);
      1: return ori(a, b);
      2: return beq(a, b);
      3: return sw(a, b);
      4: return lw(a, b);
      5: return jal();
      6: return ($urandom_range(0, 1) == 1) ? jr(a) : mk(JR, a, 0, 1'b1, c);
      default: return nop();
    endcase
  endfunction

  // ---------------- bench plumbing ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    d_type = (cur.cls < 0) ? 7'd0 : 7'(1 << cur.cls);
    d_rs   = 5'(cur.rs);
    d_rt   = 5'(cur.rt);
    d_we   = cur.we;
    d_wreg = 5'(cur.wreg);
  endtask

  task automatic check_all(input string pfx);
    obs_stall = stall;    obs_fd_rs = fwd_d_rs; obs_fd_rt = fwd_d_rt;
    obs_fe_rs = fwd_e_rs; obs_fe_rt = fwd_e_rt; obs_fm    = fwd_m_rt;
    obs_cnt   = stall_cnt;
    chk({pfx, ".stall"},    32'(obs_stall), 32'(exp_stall()));
    chk({pfx, ".fwd_d_rs"}, 32'(obs_fd_rs), exp_fd(1'b0));
    chk({pfx, ".fwd_d_rt"}, 32'(obs_fd_rt), exp_fd(1'b1));
    chk({pfx, ".fwd_e_rs"}, 32'(obs_fe_rs), exp_fe(1'b0));
    chk({pfx, ".fwd_e_rt"}, 32'(obs_fe_rt), exp_fe(1'b1));
    chk({pfx, ".fwd_m_rt"}, 32'(obs_fm),    exp_fm());
    chk({pfx, ".stall_cnt"}, 32'(obs_cnt),  model_cnt);
  endtask

  // Clock edge in the model: the pipeline shifts, D enters E unless stalled.
  task automatic advance();
    bit s = exp_stall();
    pipe_w = pipe_m;
    pipe_m = pipe_e;
    pipe_e = s ? nop() : cur;
    if (s && model_cnt < MAXCNT) model_cnt++;
  endtask

  task automatic step(input string pfx);
    drive();
    @(negedge clk);
    check_all(pfx);
    @(posedge clk);
    advance();
    #1;
  endtask

  // Present an instruction in D and hold it until the model says it issues.
  task automatic issue(input string pfx, input ins_t i, output int stalls);
    bit s;
    stalls = 0;
    cur = i;
    for (int k = 0; k < 3; k++) begin
      s = exp_stall();
      step(pfx);
      if (obs_stall === 1'b1) stalls++;
      if (!s) break;
    end
  endtask

  task automatic do_reset(input string pfx);
    rst_n = 1'b0;
    pipe_e = nop(); pipe_m = nop(); pipe_w = nop();
    model_cnt = 0;
    drive();
    #2;
    check_all(pfx);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    advance();
    #1;
  endtask

  int st;

  initial begin
    rst_n = 1'b1;
    cur   = nop();
    drive();
    #1;
    do_reset("reset");

    // Load-use on an R-type consumer.
    issue("lw1", lw(1, 0), st);
    issue("addu1", addu(2, 1, 3), st);
    chk("lw_addu.stalls", 32'(st), 1);
    chk("lw_addu.fwd_d_rs_after", 32'(obs_fd_rs), 2);
    issue("nop1", nop(), st);
    chk("lw_addu.fwd_e_rs", 32'(obs_fe_rs), 3);
    chk("lw_addu.stall_cnt", 32'(obs_cnt), 1);

    // ALU result consumed by a branch.
    do_reset("reset2");
    issue("ori4", ori(4, 0), st);
    issue("beq4", beq(4, 0), st);
    chk("ori_beq.stalls", 32'(st), 1);
    chk("ori_beq.fwd_d_rs", 32'(obs_fd_rs), 2);

    // Load consumed by jr: two stalls then the W result.
    do_reset("reset3");
    issue("lw5", lw(5, 0), st);
    issue("jr5", jr(5), st);
    chk("lw_jr.stalls", 32'(st), 2);
    chk("lw_jr.fwd_d_rs", 32'(obs_fd_rs), 3);
    chk("lw_jr.stall_cnt", 32'(obs_cnt), 2);

    // Link value forwarded straight from E.
    issue("jal", jal(), st);
    issue("jr31", jr(31), st);
    chk("jal_jr.stalls", 32'(st), 0);
    chk("jal_jr.fwd_d_rs", 32'(obs_fd_rs), 1);

    // Two link writers in flight: the younger one in E wins.
    issue("jal_a", jal(), st);
    issue("jal_b", jal(), st);
    issue("jr31b", jr(31), st);
    chk("jal_jal_jr.fwd_d_rs", 32'(obs_fd_rs), 1);

    // Store data from the preceding ALU op.
    issue("addu6", addu(6, 1, 2), st);
    issue("sw6", sw(6, 7), st);
    chk("addu_sw.stalls", 32'(st), 0);
    issue("nop_sw", nop(), st);
    chk("addu_sw.fwd_e_rt", 32'(obs_fe_rt), 2);
    chk("addu_sw.fwd_e_rs", 32'(obs_fe_rs), 0);

    // Writes to $0 never match.
    issue("addu0", addu(0, 1, 2), st);
    issue("beq0", beq(0, 0), st);
    chk("zero.fwd_d_rs", 32'(obs_fd_rs), 0);
    issue("nop0", nop(), st);
    chk("zero.fwd_e_rs", 32'(obs_fe_rs), 0);

    // Reset in the middle of a load-use stall.
    do_reset("reset4");
    issue("lw1b", lw(1, 0), st);
    issue("addu1b", addu(2, 1, 3), st);
    issue("lw1c", lw(1, 0), st);
    cur = addu(2, 1, 3);
    drive();
    @(negedge clk);
    check_all("midstall");
    chk("midstall.stall_before", 32'(obs_stall), 1);
    #1;
    do_reset("midreset");
    chk("midreset.stall", 32'(obs_stall), 0);
    chk("midreset.stall_cnt", 32'(obs_cnt), 0);
    chk("midreset.fwd_d_rs", 32'(obs_fd_rs), 0);

    // Counter saturation: 18 stalls into a 4-bit counter.
    do_reset("reset5");
    for (int k = 0; k < 9; k++) begin
      issue("sat_lw", lw(5, 0), st);
      issue("sat_beq", beq(5, 5), st);
    end
    chk("sat.stall_cnt", 32'(obs_cnt), MAXCNT);

    // Random instruction stream.
    do_reset("reset6");
    for (int k = 0; k < 300; k++) begin
      issue("rnd", rnd_ins(), st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
